uart_mmio: RTL and testbench

- Memory-mapped bridge between the CPU data bus (addr, w_data, w_en) and the UART core.
- Decodes the top three data addresses: 253 = TX data, 254 = status, 255 = RX data.
- Buffers outbound bytes in a TX FIFO and sequences tx_en/begin_flag to the UART.
- Captures received bytes into an RX FIFO so software polling can lag the line rate.

---
 rtl/uart_mmio_if.sv | 13 +
 rtl/uart_mmio.sv | 158 +++++++++++++++
 tb/tb_uart_mmio.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_if.sv
// CPU data-bus view of the UART bridge: address, store/load strobes and read-back.
// The CPU side drives the master modport and the bridge is the slave.
interface uart_mmio_if;
    logic [7:0] addr;
    logic [7:0] w_data;
    logic       w_en;
    logic       rd_en;
    logic       sel;
    logic [7:0] r_data;

    modport master (output addr, w_data, w_en, rd_en, input sel, r_data);
    modport slave  (input addr, w_data, w_en, rd_en, output sel, r_data);
endinterface

// File: rtl/uart_mmio.sv
// Purpose: MMIO bridge (253 TX data, 254 status, 255 RX data) with TX/RX byte FIFOs; optional irq via UART_MMIO_IRQ_EN.
// Latency: sel/r_data combinational; a queued byte launches on tx_en one cycle after the FSM sees busy_flag low.
// Backpressure: stores to a full TX FIFO are dropped; RX bytes arriving while full are dropped and set rx_overrun.
module uart_mmio #(
    parameter int TX_DEPTH     = 4,
    parameter int RX_DEPTH     = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    uart_mmio_if.slave bus,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       begin_flag,
    output logic       rx_en,
    input  logic       busy_flag,
    input  logic [7:0] rx_data,
    input  logic       receive_flag,
    output logic       irq
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TW  = $clog2(BUSY_TIMEOUT) + 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [7:0]   tx_mem [TX_DEPTH];
    logic [TAW:0] tx_wp, tx_rp;
    logic [7:0]   rx_mem [RX_DEPTH];
    logic [RAW:0] rx_wp, rx_rp;

    logic         tx_empty, tx_full, rx_empty, rx_full;
    logic         hit_tx, hit_st, hit_rx;
    logic         tx_push, tx_pop, rx_push, rx_pop, rx_accept, ovr_set, ovr_clr;
    logic         rx_overrun, rf_q;
    logic [1:0]   state;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]   status;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);

    assign hit_tx  = (bus.addr == 8'd253);
    assign hit_st  = (bus.addr == 8'd254);
    assign hit_rx  = (bus.addr == 8'd255);
    assign bus.sel = hit_tx | hit_st | hit_rx;
    assign status  = {3'b000, busy_flag, tx_empty, rx_overrun, ~rx_empty, tx_full};

    always_comb begin
        bus.r_data = 8'h00;
        if (hit_st)
            bus.r_data = status;
        else if (hit_rx && !rx_empty)
            bus.r_data = rx_mem[rx_rp[RAW-1:0]];
    end

    assign tx_push = bus.w_en & hit_tx & ~tx_full;
    assign tx_pop  = (state == S_LAUNCH);

    // A full RX FIFO still accepts a byte when the CPU pops in the same cycle.
    assign rx_push   = receive_flag & ~rf_q;
    assign rx_pop    = bus.rd_en & hit_rx & ~rx_empty;
    assign rx_accept = rx_push & (~rx_full | rx_pop);
    assign ovr_set   = rx_push & rx_full & ~rx_pop;
    assign ovr_clr   = bus.rd_en & hit_st;

    always_ff @(posedge clock) begin
        if (tx_push)
            tx_mem[tx_wp[TAW-1:0]] <= bus.w_data;
        if (rx_accept)
            rx_mem[rx_wp[RAW-1:0]] <= rx_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_wp      <= '0;
            tx_rp      <= '0;
            rx_wp      <= '0;
            rx_rp      <= '0;
            rx_overrun <= 1'b0;
            rf_q       <= 1'b0;
            rx_en      <= 1'b0;
        end else begin
            if (tx_push)   tx_wp <= tx_wp + 1'b1;
            if (tx_pop)    tx_rp <= tx_rp + 1'b1;
            if (rx_accept) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)    rx_rp <= rx_rp + 1'b1;
            rx_overrun <= ovr_set | (rx_overrun & ~ovr_clr);
            rf_q       <= receive_flag;
            rx_en      <= 1'b1;
        end
    end

    // tx_data is loaded on entry to LAUNCH; the head is popped as LAUNCH ends.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            tx_data    <= 8'h00;
            tx_en      <= 1'b0;
            begin_flag <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            tx_en      <= 1'b0;
            begin_flag <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!tx_empty && !busy_flag) begin
                        state      <= S_LAUNCH;
                        tx_data    <= tx_mem[tx_rp[TAW-1:0]];
                        tx_en      <= 1'b1;
                        begin_flag <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    state   <= S_WAIT_BUSY;
                    tmo_cnt <= '0;
                end
                S_WAIT_BUSY: begin
                    if (busy_flag)
                        state <= S_WAIT_DONE;
                    else if (tmo_cnt == TW'(BUSY_TIMEOUT - 1))
                        state <= S_IDLE;
                    else
                        tmo_cnt <= tmo_cnt + 1'b1;
                end
                S_WAIT_DONE: begin
                    if (!busy_flag)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_MMIO_IRQ_EN
    logic tx_irq_arm;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_irq_arm <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (bus.w_en && hit_tx)
                tx_irq_arm <= 1'b1;
            else if (bus.rd_en && hit_st)
                tx_irq_arm <= 1'b0;
            irq <= ~rx_empty | rx_overrun | (tx_empty & tx_irq_arm);
        end
    end
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_mmio.sv
// Randomized and directed bench for uart_mmio against a queue-based model of the MMIO bridge.
module tb_uart_mmio;
    localparam int TXD = 4;
    localparam int RXD = 4;
    localparam int TMO = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data, rx_data;
    logic       tx_en, begin_flag, rx_en, busy_flag, receive_flag, irq;

    always #5 clock = ~clock;

    uart_mmio_if bus();

    uart_mmio #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .BUSY_TIMEOUT(TMO)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .tx_data(tx_data), .tx_en(tx_en), .begin_flag(begin_flag), .rx_en(rx_en),
        .busy_flag(busy_flag), .rx_data(rx_data), .receive_flag(receive_flag), .irq(irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: byte queues, sticky overrun, last launched byte, UART busy timing.
    logic [7:0] m_txq[$];
    logic [7:0] m_rxq[$];
    logic [7:0] sent[$];
    int         launch_t[$];
    bit         m_ovr, m_rfq, m_arm, m_irq, prev_en;
    logic [7:0] m_last;
    int         busy_cnt, frame_len, cyc;
    bit         busy_hold, rand_frames;

    function automatic logic [7:0] exp_status();
        return {3'b000, busy_flag, m_txq.size() == 0, m_ovr, m_rxq.size() != 0, m_txq.size() == TXD};
    endfunction

    task automatic model_clear();
        m_txq.delete();
        m_rxq.delete();
        m_ovr = 0; m_rfq = 0; m_arm = 0; m_irq = 0; prev_en = 0;
        m_last = 8'h00; busy_cnt = 0;
    endtask

    task automatic set_idle();
        bus.addr = 8'h00; bus.w_data = 8'h00; bus.w_en = 1'b0; bus.rd_en = 1'b0;
    endtask

    // One clock: check outputs against the model, advance the model over the edge.
    task automatic cycle();
        logic [7:0] a, er;
        logic       ten;
        bit         rpush, rpop, irq_n;
        #1;
        a = bus.addr;
        check("sel", bus.sel, a >= 8'd253);
        er = 8'h00;
        if (a == 8'd254) er = exp_status();
        else if (a == 8'd255 && m_rxq.size() != 0) er = m_rxq[0];
        check("r_data", bus.r_data, er);
        ten = tx_en;
        check("begin_flag", begin_flag, ten);
        if (ten && m_txq.size() == 0)
            check("launch_empty", ten, 1'b0);
        else
            check("tx_data", tx_data, ten ? m_txq[0] : m_last);
        if (ten) begin
            check("launch_busy", busy_flag, 1'b0);
            check("pulse_len", prev_en, 1'b0);
        end
`ifdef UART_MMIO_IRQ_EN
        check("irq", irq, m_irq);
`else
        check("irq", irq, 1'b0);
`endif
        irq_n = (m_rxq.size() != 0) | m_ovr | ((m_txq.size() == 0) & m_arm);
        if (bus.w_en && a == 8'd253) m_arm = 1;
        else if (bus.rd_en && a == 8'd254) m_arm = 0;
        m_irq = irq_n;

        if (bus.w_en && a == 8'd253 && m_txq.size() < TXD) m_txq.push_back(bus.w_data);
        if (ten && m_txq.size() != 0) begin
            m_last = m_txq[0];
            sent.push_back(m_txq[0]);
            launch_t.push_back(cyc);
            void'(m_txq.pop_front());
        end

        rpush = receive_flag && !m_rfq;
        rpop  = bus.rd_en && a == 8'd255 && m_rxq.size() != 0;
        if (rpop) void'(m_rxq.pop_front());
        if (bus.rd_en && a == 8'd254) m_ovr = 0;
        if (rpush) begin
            if (m_rxq.size() < RXD) m_rxq.push_back(rx_data);
            else m_ovr = 1;
        end
        m_rfq   = receive_flag;
        prev_en = ten;

        if (ten) busy_cnt = rand_frames ? int'($urandom_range(0, 6)) : frame_len;
        else if (busy_cnt > 0) busy_cnt--;
        cyc++;
        @(posedge clock);
        #1 busy_flag = busy_hold | (busy_cnt > 0);
        @(negedge clock);
    endtask

    task automatic store(input logic [7:0] d);
        set_idle(); bus.addr = 8'd253; bus.w_data = d; bus.w_en = 1'b1;
        cycle();
        set_idle();
    endtask

    task automatic read_rx(input string tag, input logic [7:0] exp);
        set_idle(); bus.addr = 8'd255; bus.rd_en = 1'b1;
        #1 check(tag, bus.r_data, exp);
        cycle();
        set_idle();
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_data = d; receive_flag = 1'b1;
        cycle();
        receive_flag = 1'b0;
        cycle();
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Reset with stimuli active; outputs must clear immediately, rx_en rises after the first edge.
    task automatic do_reset();
        bus.addr = 8'd253; bus.w_data = 8'h77; bus.w_en = 1'b1; bus.rd_en = 1'b1;
        receive_flag = 1'b1; rx_data = 8'h55;
        busy_hold = 0; busy_flag = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_tx_en", tx_en, 1'b0);
        check("rst_begin", begin_flag, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_rx_en", rx_en, 1'b0);
        check("rst_irq", irq, 1'b0);
        bus.addr = 8'd254;
        #1 check("rst_status", bus.r_data, 8'h08);
        repeat (2) @(posedge clock);
        @(negedge clock);
        model_clear();
        set_idle(); receive_flag = 1'b0;
        reset_n = 1'b1;
        #1 check("rx_en_pre", rx_en, 1'b0);
        cycle();
        check("rx_en_post", rx_en, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0; busy_flag = 1'b0; receive_flag = 1'b0; rx_data = 8'h00;
        busy_hold = 0; rand_frames = 0; frame_len = 0; cyc = 0;
        set_idle(); model_clear();
        @(negedge clock);
        do_reset();

        // Single launch, then a queued byte waits for busy to drop.
        sent.delete(); launch_t.delete(); frame_len = 10;
        store(8'h41); store(8'h42);
        idle_cycles(30);
        check("t1_sent_n", sent.size(), 2);
        if (sent.size() == 2) begin
            check("t1_b0", sent[0], 8'h41);
            check("t1_b1", sent[1], 8'h42);
            check("t1_gap", (launch_t[1] - launch_t[0]) >= 13, 1'b1);
        end

        // TX FIFO overflow while UART busy.
        sent.delete(); busy_hold = 1; frame_len = 2;
        #1 busy_flag = 1'b1;
        for (int i = 1; i <= 4; i++) store(8'(i));
        bus.addr = 8'd254;
        #1 check("t2_full", bus.r_data[0], 1'b1);
        cycle();
        store(8'h05);
        busy_hold = 0;
        idle_cycles(40);
        check("t2_sent_n", sent.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < sent.size()) check("t2_order", sent[i], 8'(i + 1));

        // RX overrun and drain.
        for (int i = 0; i < 5; i++) rx_pulse(8'hA0 + 8'(i));
        bus.addr = 8'd254;
        #1 check("t3_status", bus.r_data, 8'h0E);
        cycle();
        for (int i = 0; i < 4; i++) read_rx("t3_rx", 8'hA0 + 8'(i));
        bus.addr = 8'd254; bus.rd_en = 1'b1;
        cycle();
        set_idle(); bus.addr = 8'd254;
        #1 check("t3_clr", bus.r_data, 8'h08);
        cycle();

        // Push and pop together on a full RX FIFO.
        for (int i = 0; i < 4; i++) rx_pulse(8'hB0 + 8'(i));
        rx_data = 8'hB4; receive_flag = 1'b1; bus.addr = 8'd255; bus.rd_en = 1'b1;
        cycle();
        receive_flag = 1'b0; set_idle(); bus.addr = 8'd254;
        #1 check("t4_no_ovr", bus.r_data[2], 1'b0);
        cycle();
        for (int i = 1; i <= 4; i++) read_rx("t4_rx", 8'hB0 + 8'(i));

        // Busy never rises: timeout back to IDLE, then reset during WAIT_DONE.
        sent.delete(); launch_t.delete(); frame_len = 0;
        store(8'hC1); store(8'hC2);
        idle_cycles(15);
        check("t5_sent_n", sent.size(), 2);
        if (launch_t.size() == 2) check("t5_gap", launch_t[1] - launch_t[0], TMO + 2);
        frame_len = 50;
        store(8'hC3); store(8'hC4);
        idle_cycles(6);
        check("t5_c3", sent.size(), 3);
        do_reset();

        // Randomized traffic.
        rand_frames = 1;
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 4))
                0: bus.addr = 8'd253;
                1: bus.addr = 8'd254;
                2, 3: bus.addr = 8'd255;
                default: bus.addr = 8'($urandom_range(0, 255));
            endcase
            bus.w_data = 8'($urandom);
            bus.w_en   = ($urandom_range(0, 2) == 0);
            bus.rd_en  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) receive_flag = ~receive_flag;
            rx_data = 8'($urandom);
            cycle();
        end
        set_idle();
        idle_cycles(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
